// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU execute definitions: alu_op encodings from ALU control decode
// and the execute-unit FSM state encoding.
package alu_exec_unit_pkg;

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_SLL     = 4'h5;
    localparam logic [3:0] OP_SRL     = 4'h6;
    localparam logic [3:0] OP_SUB_BEQ = 4'h7;
    localparam logic [3:0] OP_SUB_BNE = 4'h8;
    localparam logic [3:0] OP_SUB_BLT = 4'h9;
    localparam logic [3:0] OP_SUB_BGE = 4'hA;
    localparam logic [3:0] OP_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_exec_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation-in / result-out handshake bundle of the ALU execute unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            bcond;
    logic            busy;

    modport master (
        output in_valid, alu_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, alu_result, bcond, busy
    );

    modport slave (
        input  in_valid, alu_op, in_a, in_b, out_ready,
        output in_ready, out_valid, alu_result, bcond, busy
    );
endinterface

// File: rtl/alu_exec_unit_shifter.sv
// Iterative logical shifter: moves up to SHIFT_STEP bits per cycle and flags
// the cycle whose step finishes the shift (o_result is then the final value).
module alu_iter_shifter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic                    i_dir,
    input  logic [XLEN-1:0]         i_data,
    input  logic [$clog2(XLEN)-1:0] i_shamt,
    output logic [XLEN-1:0]         o_result,
    output logic                    o_done
);
    // One extra bit so the counter can also represent SHIFT_STEP == XLEN.
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    logic [XLEN-1:0] r_data;
    logic            r_dir;
    logic [CW-1:0]   r_rem;
    logic [CW-1:0]   w_step;
    logic [XLEN-1:0] w_next;

    assign w_step   = (r_rem > STEP) ? STEP : r_rem;
    assign w_next   = r_dir ? (r_data >> w_step) : (r_data << w_step);
    assign o_result = w_next;
    assign o_done   = (r_rem != '0) && (r_rem <= STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= {1'b0, i_shamt};
        end else if (r_rem != '0) begin
            r_rem <= r_rem - w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
            r_dir  <= i_dir;
        end else if (r_rem != '0) begin
            r_data <= w_next;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ops, iterative SLL/SRL, registered result.
// Optional synchronous flush port enabled by defining ALU_EXEC_FLUSH_EN.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef ALU_EXEC_FLUSH_EN
    input  logic             flush,
`endif
    alu_exec_unit_if.slave   bus
);
    localparam int SW = $clog2(XLEN);

    alu_exec_state_e r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_bcond;
    logic            r_busy;

    logic                w_flush;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_start_shift;
    logic [SW-1:0]       w_shamt;
    logic [XLEN-1:0]     w_result;
    logic                w_bcond;
    logic [XLEN-1:0]     w_diff;
    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic [XLEN-1:0]     w_sh_result;
    logic                w_sh_done;

`ifdef ALU_EXEC_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_in_ready    = ~w_flush & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_shamt       = bus.in_b[SW-1:0];
    assign w_start_shift = w_accept & is_shift_op(bus.alu_op) & (w_shamt != '0);

    assign w_diff = bus.in_a - bus.in_b;
    assign w_a_s  = bus.in_a;
    assign w_b_s  = bus.in_b;

    // Single-cycle datapath; shifts by zero pass operand A through.
    always_comb begin
        w_result = '0;
        w_bcond  = 1'b0;
        case (bus.alu_op)
            OP_ADD:     w_result = bus.in_a + bus.in_b;
            OP_SUB:     w_result = w_diff;
            OP_AND:     w_result = bus.in_a & bus.in_b;
            OP_OR:      w_result = bus.in_a | bus.in_b;
            OP_XOR:     w_result = bus.in_a ^ bus.in_b;
            OP_SLL,
            OP_SRL:     w_result = bus.in_a;
            OP_SUB_BEQ: begin w_result = w_diff; w_bcond = (bus.in_a == bus.in_b); end
            OP_SUB_BNE: begin w_result = w_diff; w_bcond = (bus.in_a != bus.in_b); end
            OP_SUB_BLT: begin w_result = w_diff; w_bcond = (w_a_s < w_b_s);        end
            OP_SUB_BGE: begin w_result = w_diff; w_bcond = (w_a_s >= w_b_s);       end
            default:    ;
        endcase
    end

    alu_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_start_shift),
        .i_dir    (bus.alu_op == OP_SRL),
        .i_data   (bus.in_a),
        .i_shamt  (w_shamt),
        .o_result (w_sh_result),
        .o_done   (w_sh_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_bcond     <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_start_shift) begin
                            r_state     <= SHIFT;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_result;
                            r_bcond     <= w_bcond;
                        end
                    end else if ((r_state == DONE) && bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_sh_done) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_sh_result;
                        r_bcond     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.alu_result = r_result;
    assign bus.bcond      = r_bcond;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32, SHIFT_STEP=1).
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
    } op_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } sh_vec_t;

    logic clk = 1'b0;
    logic reset_n;
`ifdef ALU_EXEC_FLUSH_EN
    logic flush = 1'b0;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef ALU_EXEC_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = OP_DEFAULT;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid); end
        n_checks++; if (bus.alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_result actual=%h required=0", bus.alu_result); end
        n_checks++; if (bus.bcond !== 1'b0) begin n_fail++; $display("FAIL reset_bcond actual=%b required=0", bus.bcond); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready actual=%b required=1", bus.in_ready); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cycle_ops();
        op_vec_t v [16];
        v[0]  = '{OP_ADD,     32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        v[1]  = '{OP_SUB,     32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        v[2]  = '{OP_AND,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        v[3]  = '{OP_OR,      32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        v[4]  = '{OP_XOR,     32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        v[5]  = '{OP_SUB_BLT, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1};
        v[6]  = '{OP_SUB_BGE, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        v[7]  = '{OP_SUB_BLT, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
        v[8]  = '{OP_SUB_BGE, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1};
        v[9]  = '{OP_SUB_BEQ, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        v[10] = '{OP_SUB_BNE, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
        v[11] = '{OP_SUB_BNE, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1};
        v[12] = '{4'hF,       32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b0};
        v[13] = '{4'hC,       32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b0};
        v[14] = '{OP_SLL,     32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0};
        v[15] = '{OP_SRL,     32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0};
        for (int i = 0; i < 16; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            tick();
            bus.in_valid = 1'b0;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_out_valid actual=%b required=1", i, bus.out_valid); end
            n_checks++; if (bus.alu_result !== v[i].res) begin n_fail++; $display("FAIL op%0d_result actual=%h required=%h", i, bus.alu_result, v[i].res); end
            n_checks++; if (bus.bcond !== v[i].bc) begin n_fail++; $display("FAIL op%0d_bcond actual=%b required=%b", i, bus.bcond, v[i].bc); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL op%0d_in_ready_held actual=%b required=0", i, bus.in_ready); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_drain actual=%b required=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_shift();
        sh_vec_t v [5];
        int cyc;
        int busy_cyc;
        v[0] = '{OP_SLL, 32'h0000_0001, 32'd5,         32'h0000_0020, 6};
        v[1] = '{OP_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001, 32};
        v[2] = '{OP_SLL, 32'hFFFF_FFFF, 32'd31,        32'h8000_0000, 32};
        v[3] = '{OP_SRL, 32'hFFFF_FFFF, 32'd4,         32'h0FFF_FFFF, 5};
        v[4] = '{OP_SLL, 32'h0000_0003, 32'h0000_0101, 32'h0000_0006, 2};
        for (int i = 0; i < 5; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            tick();
            cyc = 1;
            busy_cyc = 0;
            // A competing op offered during the shift must be ignored.
            drive(OP_ADD, 32'h7, 32'h7);
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sh%0d_in_ready_busy actual=%b required=0", i, bus.in_ready); end
            while (bus.out_valid !== 1'b1 && cyc < 100) begin
                if (bus.busy === 1'b1) busy_cyc++;
                tick();
                cyc++;
            end
            bus.in_valid = 1'b0;
            n_checks++; if (cyc != v[i].lat) begin n_fail++; $display("FAIL sh%0d_latency actual=%0d required=%0d", i, cyc, v[i].lat); end
            n_checks++; if (busy_cyc != v[i].lat - 1) begin n_fail++; $display("FAIL sh%0d_busy_cycles actual=%0d required=%0d", i, busy_cyc, v[i].lat - 1); end
            n_checks++; if (bus.alu_result !== v[i].res) begin n_fail++; $display("FAIL sh%0d_result actual=%h required=%h", i, bus.alu_result, v[i].res); end
            n_checks++; if (bus.bcond !== 1'b0) begin n_fail++; $display("FAIL sh%0d_bcond actual=%b required=0", i, bus.bcond); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sh%0d_busy_done actual=%b required=0", i, bus.busy); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_XOR, 32'h0F0F_0F0F, 32'h00FF_00FF);
        tick();
        drive(OP_ADD, 32'd10, 32'd20);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d_out_valid actual=%b required=1", i, bus.out_valid); end
            n_checks++; if (bus.alu_result !== 32'h0FF0_0FF0) begin n_fail++; $display("FAIL hold%0d_result actual=%h required=0ff00ff0", i, bus.alu_result); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_in_ready actual=%b required=0", i, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready actual=%b required=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid actual=%b required=1", bus.out_valid); end
        n_checks++; if (bus.alu_result !== 32'd30) begin n_fail++; $display("FAIL b2b_result actual=%h required=0000001e", bus.alu_result); end
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain actual=%b required=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        drive(OP_SLL, 32'h1, 32'd20);
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before actual=%b required=1", bus.busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid actual=%b required=0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy actual=%b required=0", bus.busy); end
        n_checks++; if (bus.alu_result !== 32'h0) begin n_fail++; $display("FAIL midrst_result actual=%h required=0", bus.alu_result); end
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result actual=%b required=0", seen); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle actual=%b required=1", bus.in_ready); end
    endtask

`ifdef ALU_EXEC_FLUSH_EN
    task automatic test_flush();
        drive(OP_SLL, 32'h1, 32'd10);
        tick();
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before actual=%b required=1", bus.busy); end
        flush = 1'b1;
        drive(OP_ADD, 32'h1, 32'h1);
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready actual=%b required=0", bus.in_ready); end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid actual=%b required=0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy actual=%b required=0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle actual=%b required=1", bus.in_ready); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept actual=%b required=0", bus.out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cycle_ops();
        test_shift();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef ALU_EXEC_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
